// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: 3-stage pipelined unsigned multiplier with a selectable
// approximate mode and error statistics.
//
// In approximate mode, the low APPROX_COLS product columns are formed by
// OR-ing their partial products, with no carry out of those columns. The
// remaining columns are summed exactly. Every result carries its absolute
// error against the exact product. Delivered results update a saturating
// mismatch counter and a running maximum error.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand transaction offered
//   in_ready   out  transaction accepted this cycle (0 while rst = 1)
//   in_a       in   WIDTH-bit unsigned multiplicand
//   in_b       in   WIDTH-bit unsigned multiplier
//   in_mode    in   0 = exact, 1 = approximate
//   out_valid  out  result available
//   out_ready  in   downstream accepts the result
//   out_p      out  2*WIDTH-bit product in the transaction's mode
//   out_mode   out  mode of the transaction on out_p
//   out_err    out  |out_p - a*b|; 0 in exact mode
//   stats_clr  in   clear err_cnt/err_max; a same-cycle delivery is not counted
//   err_cnt    out  saturating count of delivered results with out_err != 0
//   err_max    out  largest out_err delivered since the last clear
module approx_mul_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_COLS = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 out_mode,
    output logic [2*WIDTH-1:0]   out_err,
    input  logic                 stats_clr,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [2*WIDTH-1:0]   err_max
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    // Stage 1: operands and mode
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s1_mode_q;

    // Stage 2: exact and approximate products
    logic             s2_valid_q;
    logic [PW-1:0]    s2_exact_q;
    logic [PW-1:0]    s2_approx_q;
    logic             s2_mode_q;

    // Stage 3: output registers
    logic             out_valid_q;
    logic [PW-1:0]    out_p_q;
    logic             out_mode_q;
    logic [PW-1:0]    out_err_q;

    // Statistics
    logic [CNT_W-1:0] err_cnt_q;
    logic [PW-1:0]    err_max_q;

    logic             en;
    logic             deliver;
    logic [PW-1:0]    exact_prod;
    logic [PW-1:0]    approx_hi;
    logic [PW-1:0]    approx_lo;
    logic [PW-1:0]    col_bit;
    logic [PW-1:0]    approx_prod;
    logic [PW-1:0]    s3_p;
    logic [PW-1:0]    s3_err;

    // Whole pipeline advances together; bubbles are carried, not collapsed.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en && !rst;
    assign deliver  = out_valid_q && out_ready;

    // S1 -> S2 reduction
    always_comb begin
        exact_prod = PW'(s1_a_q) * PW'(s1_b_q);
        approx_hi  = '0;
        approx_lo  = '0;
        col_bit    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            for (int j = 0; j < int'(WIDTH); j++) begin
                col_bit = PW'(1) << (i + j);
                if (s1_a_q[i] && s1_b_q[j]) begin
                    if ((i + j) >= int'(APPROX_COLS)) begin
                        approx_hi = approx_hi + col_bit;
                    end else begin
                        // Low columns: OR only, so nothing carries upward.
                        approx_lo = approx_lo | col_bit;
                    end
                end
            end
        end
        // Low columns sit entirely below the lowest bit of approx_hi.
        approx_prod = approx_hi | approx_lo;
    end

    // S2 -> S3 selection and error
    always_comb begin
        s3_p = s2_mode_q ? s2_approx_q : s2_exact_q;
        if (s3_p >= s2_exact_q) begin
            s3_err = s3_p - s2_exact_q;
        end else begin
            s3_err = s2_exact_q - s3_p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_exact_q  <= '0;
            s2_approx_q <= '0;
            s2_mode_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_mode_q  <= 1'b0;
            out_err_q   <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q    <= in_a;
                s1_b_q    <= in_b;
                s1_mode_q <= in_mode;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_exact_q  <= exact_prod;
                s2_approx_q <= approx_prod;
                s2_mode_q   <= s1_mode_q;
            end
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_p_q    <= s3_p;
                out_mode_q <= s2_mode_q;
                out_err_q  <= s3_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            err_cnt_q <= '0;
            err_max_q <= '0;
        end else if (deliver) begin
            if ((out_err_q != '0) && (err_cnt_q != CntMax)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
            if (out_err_q > err_max_q) begin
                err_max_q <= out_err_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_mode  = out_mode_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;
    assign err_max   = err_max_q;

endmodule

// File: tb/tb_approx_mul_pipe.sv
module tb_approx_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_mode;
    logic        out_ready;
    logic        stats_clr;

    logic        rdy0, ov0, m0;
    logic [15:0] p0, e0, max0;
    logic [3:0]  cnt0;
    logic        rdy1, ov1, m1;
    logic [15:0] p1, e1, max1, cnt1;
    logic        rdy2, ov2, m2;
    logic [15:0] p2, e2, max2, cnt2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    approx_mul_pipe #(.WIDTH(8), .APPROX_COLS(4), .CNT_W(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .out_valid(ov0), .out_ready(out_ready), .out_p(p0), .out_mode(m0),
        .out_err(e0), .stats_clr(stats_clr), .err_cnt(cnt0), .err_max(max0)
    );

    approx_mul_pipe #(.WIDTH(8), .APPROX_COLS(0), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .out_valid(ov1), .out_ready(out_ready), .out_p(p1), .out_mode(m1),
        .out_err(e1), .stats_clr(stats_clr), .err_cnt(cnt1), .err_max(max1)
    );

    approx_mul_pipe #(.WIDTH(8), .APPROX_COLS(15), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .out_valid(ov2), .out_ready(out_ready), .out_p(p2), .out_mode(m2),
        .out_err(e2), .stats_clr(stats_clr), .err_cnt(cnt2), .err_max(max2)
    );

    // Reference: exact product, minus the exact weight of the low columns, plus their OR bits.
    function automatic logic [15:0] ref_approx(input logic [7:0] a, input logic [7:0] b,
                                               input int ac);
        logic [15:0] ex, lo_sum, lo_or;
        int cnt;
        ex     = 16'(a) * 16'(b);
        lo_sum = '0;
        lo_or  = '0;
        for (int k = 0; k < ac; k++) begin
            cnt = 0;
            for (int i = 0; i < 8; i++) begin
                if ((k - i) >= 0 && (k - i) < 8) begin
                    if (a[i] && b[k - i]) cnt++;
                end
            end
            lo_sum = lo_sum + (16'(cnt) << k);
            if (cnt > 0) lo_or[k] = 1'b1;
        end
        return ex - lo_sum + lo_or;
    endfunction

    // Offer one transaction and wait until its result sits on the output.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic m);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        stats_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (rdy0 !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", rdy0);
                   else n_pass++;
        n_total++; if (ov0 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ov0);
                   else n_pass++;
        n_total++; if (p0 !== 16'd0 || e0 !== 16'd0 || m0 !== 1'b0)
                       $display("FAIL reset_outputs: got p=%0d err=%0d mode=%b want 0/0/0",
                                p0, e0, m0);
                   else n_pass++;
        n_total++; if (cnt0 !== 4'd0 || max0 !== 16'd0)
                       $display("FAIL reset_stats: got cnt=%0d max=%0d want 0/0", cnt0, max0);
                   else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (rdy0 !== 1'b1) $display("FAIL release_in_ready: got %b want 1", rdy0);
                   else n_pass++;
    endtask

    task automatic test_exact;
        run_txn(8'd255, 8'd255, 1'b0);
        n_total++; if (ov0 !== 1'b1) $display("FAIL exact_latency: out_valid got %b want 1", ov0);
                   else n_pass++;
        n_total++; if (p0 !== 16'd65025 || e0 !== 16'd0 || m0 !== 1'b0)
                       $display("FAIL exact_255: got p=%0d err=%0d mode=%b want 65025/0/0",
                                p0, e0, m0);
                   else n_pass++;
        @(posedge clk); #1;
        n_total++; if (cnt0 !== 4'd0 || ov0 !== 1'b0)
                       $display("FAIL exact_stats: got cnt=%0d ov=%b want 0/0", cnt0, ov0);
                   else n_pass++;
    endtask

    task automatic test_approx;
        run_txn(8'd255, 8'd255, 1'b1);
        n_total++; if (ov0 !== 1'b1 || p0 !== 16'd64991 || e0 !== 16'd34 || m0 !== 1'b1)
                       $display("FAIL approx_255: got ov=%b p=%0d err=%0d mode=%b want 1/64991/34/1",
                                ov0, p0, e0, m0);
                   else n_pass++;
        run_txn(8'd3, 8'd3, 1'b1);
        n_total++; if (ov0 !== 1'b1 || p0 !== 16'd7 || e0 !== 16'd2)
                       $display("FAIL approx_3: got ov=%b p=%0d err=%0d want 1/7/2", ov0, p0, e0);
                   else n_pass++;
        @(posedge clk); #1;
        n_total++; if (cnt0 !== 4'd2 || max0 !== 16'd34)
                       $display("FAIL approx_stats: got cnt=%0d max=%0d want 2/34", cnt0, max0);
                   else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0]  va [10];
        logic [7:0]  vb [10];
        logic        vm [10];
        logic [15:0] exp_p;
        logic [15:0] prev_p;
        logic        prev_stall;
        int          sent, rcv;
        for (int i = 0; i < 10; i++) begin
            va[i] = 8'(17 + i * 23);
            vb[i] = 8'(5 + i * 19);
            vm[i] = ((i % 2) == 1);
        end
        sent       = 0;
        rcv        = 0;
        prev_stall = 1'b0;
        prev_p     = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 5 && cyc <= 8);
            if (sent < 10) begin
                in_valid = 1'b1;
                in_a     = va[sent];
                in_b     = vb[sent];
                in_mode  = vm[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (ov0 && !out_ready) begin
                n_total++; if (rdy0 !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", rdy0);
                           else n_pass++;
                if (prev_stall) begin
                    n_total++; if (p0 !== prev_p)
                                   $display("FAIL stall_hold: got p=%0d want %0d", p0, prev_p);
                               else n_pass++;
                end
                prev_stall = 1'b1;
                prev_p     = p0;
            end else begin
                prev_stall = 1'b0;
            end
            if (ov0 && out_ready) begin
                n_total++;
                if (rcv >= 10) begin
                    $display("FAIL b2b_extra: got result %0d want none", rcv);
                end else begin
                    exp_p = vm[rcv] ? ref_approx(va[rcv], vb[rcv], 4) : 16'(va[rcv]) * 16'(vb[rcv]);
                    if (p0 !== exp_p || m0 !== vm[rcv])
                        $display("FAIL b2b_result%0d: got p=%0d mode=%b want %0d/%b",
                                 rcv, p0, m0, exp_p, vm[rcv]);
                    else n_pass++;
                end
                rcv++;
            end
            if (in_valid && rdy0) sent++;
        end
        out_ready = 1'b1;
        n_total++; if (rcv != 10) $display("FAIL b2b_count: got %0d want 10", rcv);
                   else n_pass++;
    endtask

    task automatic test_saturate;
        int sent, rcv;
        @(posedge clk); #1;
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid = (sent < 20);
            in_a     = 8'd255;
            in_b     = 8'd255;
            in_mode  = 1'b1;
            #1;
            if (ov0 && out_ready) rcv++;
            if (in_valid && rdy0) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_total++; if (rcv != 20) $display("FAIL sat_count: got %0d deliveries want 20", rcv);
                   else n_pass++;
        n_total++; if (cnt0 !== 4'd15 || max0 !== 16'd34)
                       $display("FAIL sat_value: got cnt=%0d max=%0d want 15/34", cnt0, max0);
                   else n_pass++;
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        #1;
        n_total++; if (cnt0 !== 4'd0 || max0 !== 16'd0)
                       $display("FAIL clr_stats: got cnt=%0d max=%0d want 0/0", cnt0, max0);
                   else n_pass++;
        // A delivery coinciding with the clear must not be counted.
        run_txn(8'd3, 8'd3, 1'b1);
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        #1;
        n_total++; if (cnt0 !== 4'd0 || max0 !== 16'd0)
                       $display("FAIL clr_discard: got cnt=%0d max=%0d want 0/0", cnt0, max0);
                   else n_pass++;
    endtask

    task automatic test_mid_reset;
        logic stale;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 1'b1;
        in_b      = 8'd255;
        for (int k = 0; k < 3; k++) begin
            in_a = 8'(253 + k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        n_total++; if (ov0 !== 1'b1) $display("FAIL midrst_fill: out_valid got %b want 1", ov0);
                   else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_total++; if (ov0 !== 1'b0 || cnt0 !== 4'd0 || rdy0 !== 1'b1)
                       $display("FAIL midrst_after: got ov=%b cnt=%0d rdy=%b want 0/0/1",
                                ov0, cnt0, rdy0);
                   else n_pass++;
        stale = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ov0 || ov1 || ov2) stale = 1'b1;
        end
        n_total++; if (stale !== 1'b0) $display("FAIL midrst_stale: got %b want 0", stale);
                   else n_pass++;
    endtask

    task automatic test_random;
        logic [16:0] q[$];
        logic [16:0] t;
        logic [15:0] ex, a4, a15, ep0, ep1, ep2, ee0, ee2;
        for (int cyc = 0; cyc < 430; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 400) begin
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
            in_a    = 8'($urandom);
            in_b    = 8'($urandom);
            in_mode = 1'($urandom);
            #1;
            if (ov0 && out_ready) begin
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL rnd_extra: got unexpected result p=%0d want none", p0);
                end else begin
                    t   = q.pop_front();
                    ex  = 16'(t[15:8]) * 16'(t[7:0]);
                    a4  = ref_approx(t[15:8], t[7:0], 4);
                    a15 = ref_approx(t[15:8], t[7:0], 15);
                    ep0 = t[16] ? a4 : ex;
                    ep1 = ex;
                    ep2 = t[16] ? a15 : ex;
                    ee0 = ex - ep0;
                    ee2 = ex - ep2;
                    if (p0 !== ep0 || e0 !== ee0 || m0 !== t[16] || !ov1 || !ov2 ||
                        p1 !== ep1 || e1 !== 16'd0 || p2 !== ep2 || e2 !== ee2)
                        $display("FAIL rnd a=%0d b=%0d m=%b: got %0d/%0d %0d/%0d %0d/%0d want %0d/%0d %0d/0 %0d/%0d",
                                 t[15:8], t[7:0], t[16], p0, e0, p1, e1, p2, e2,
                                 ep0, ee0, ep1, ep2, ee2);
                    else n_pass++;
                end
            end
            if (in_valid && rdy0) q.push_back({in_mode, in_a, in_b});
        end
        n_total++; if (q.size() != 0) $display("FAIL rnd_lost: got %0d pending want 0", q.size());
                   else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_exact();
        test_approx();
        test_back_to_back();
        test_saturate();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
